// File: rtl/spi_pkg.sv
// Shared types and constants for the mode-0 SPI responder.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam bit CPOL       = 1'b0;
  localparam bit CPHA       = 1'b0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_rx_tx_sync_edge.sv
// Multi-flop synchronizer for one SPI pin with rise/fall pulses derived
// from the synchronized value and a one-cycle delayed copy.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst_n,
  input  logic d_in,
  output logic q_sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_in};
      r_dly  <= r_sync[STAGES-1];
    end
  end

  assign q_sync = r_sync[STAGES-1];
  assign rise   = r_sync[STAGES-1] & ~r_dly;
  assign fall   = ~r_sync[STAGES-1] & r_dly;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// Mode-0 SPI responder: oversampled pins, byte receive with valid pulse,
// byte transmit from a valid/ready source with FILL on underrun.
//
// state  | meaning
// IDLE   | cs_n high (or not yet seen high since reset); sck ignored
// ACTIVE | frame in progress; shift on sck edges
module spi_slave_rx_tx
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter int                    CNT_W       = 16,
  parameter logic [SPI_BYTE_W-1:0] FILL        = 8'h00
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  underrun,
  output logic                  busy,
  output logic                  frame_done,
  output logic [2:0]            bit_cnt,
  output logic [CNT_W-1:0]      byte_cnt
);

  localparam logic [2:0] FLUSH_CYC = 3'(SYNC_STAGES + 1);

  logic w_cs_s, w_cs_rise, w_cs_fall;
  logic w_sck_s, w_sck_rise, w_sck_fall;
  logic w_mosi_s, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clock (clock), .rst_n (rst_n), .d_in (cs_n),
    .q_sync(w_cs_s), .rise (w_cs_rise), .fall (w_cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clock (clock), .rst_n (rst_n), .d_in (sck),
    .q_sync(w_sck_s), .rise (w_sck_rise), .fall (w_sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clock (clock), .rst_n (rst_n), .d_in (mosi),
    .q_sync(w_mosi_s), .rise (w_mosi_rise), .fall (w_mosi_fall)
  );

  assign w_unused = w_sck_s ^ w_mosi_rise ^ w_mosi_fall;

  spi_state_e            r_state, w_state_nxt;
  logic [2:0]            r_flush_cnt;
  logic                  r_armed;
  logic [SPI_BYTE_W-1:0] r_tx_shift, r_rx_shift, r_rx_data;
  logic                  r_rx_valid, r_tx_ready, r_underrun, r_frame_done;
  logic [2:0]            r_bit_cnt;
  logic [CNT_W-1:0]      r_byte_cnt;

  logic w_start, w_stop, w_rx_edge, w_tx_edge, w_load;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_stop      = 1'b0;
    w_rx_edge   = 1'b0;
    w_tx_edge   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall && r_armed) begin
          w_state_nxt = ACTIVE;
          w_start     = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_stop      = 1'b1;
        end else begin
          w_rx_edge = w_sck_rise;
          w_tx_edge = w_sck_fall;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_load = w_start | (w_tx_edge & (r_bit_cnt == 3'd0) & (r_byte_cnt != '0));
  end

  // A cs_n that was already low through reset must not look like a new frame:
  // only arm once the synchronizer has flushed and shows cs_n high.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= FLUSH_CYC;
      r_armed     <= 1'b0;
    end else begin
      if (r_flush_cnt != 3'd0) r_flush_cnt <= r_flush_cnt - 3'd1;
      else if (w_cs_s)         r_armed     <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_tx_ready   <= 1'b0;
      r_underrun   <= 1'b0;
      r_frame_done <= 1'b0;
      r_bit_cnt    <= 3'd0;
      r_byte_cnt   <= '0;
    end else begin
      r_rx_valid   <= 1'b0;
      r_tx_ready   <= 1'b0;
      r_underrun   <= 1'b0;
      r_frame_done <= w_stop;

      if (w_load) begin
        r_tx_shift <= tx_valid ? tx_data : FILL;
        r_tx_ready <= tx_valid;
        r_underrun <= ~tx_valid;
      end else if (w_tx_edge) begin
        r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
      end

      if (w_start) begin
        r_bit_cnt  <= 3'd0;
        r_byte_cnt <= '0;
      end

      if (w_stop) r_bit_cnt <= 3'd0;

      if (w_rx_edge) begin
        r_rx_shift <= {r_rx_shift[SPI_BYTE_W-2:0], w_mosi_s};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_rx_data  <= {r_rx_shift[SPI_BYTE_W-2:0], w_mosi_s};
          r_rx_valid <= 1'b1;
          if (r_byte_cnt != {CNT_W{1'b1}}) r_byte_cnt <= r_byte_cnt + 1'b1;
        end
      end
    end
  end

  assign miso       = r_tx_shift[SPI_BYTE_W-1];
  assign miso_oe    = ~w_cs_s;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign tx_ready   = r_tx_ready;
  assign underrun   = r_underrun;
  assign busy       = (r_state == ACTIVE);
  assign frame_done = r_frame_done;
  assign bit_cnt    = r_bit_cnt;
  assign byte_cnt   = r_byte_cnt;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed bench for spi_slave_rx_tx: a pin-level mode-0 master plus a
// byte-level model of what must be received and read back.
module tb_spi_slave_rx_tx;

  logic        clock = 1'b0;
  logic        rst_n, cs_n, sck, mosi;
  logic        miso, miso_oe;
  logic [7:0]  rx_data, tx_data;
  logic        rx_valid, tx_valid, tx_ready, underrun, busy, frame_done;
  logic [2:0]  bit_cnt;
  logic [15:0] byte_cnt;

  spi_slave_rx_tx #(.SYNC_STAGES(2), .CNT_W(16), .FILL(8'h00)) dut (
    .clock(clock), .rst_n(rst_n), .cs_n(cs_n), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .underrun(underrun), .busy(busy), .frame_done(frame_done),
    .bit_cnt(bit_cnt), .byte_cnt(byte_cnt)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_rx, cnt_txr, cnt_unr, cnt_fd;

  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];
  logic [7:0] mo [0:7];
  logic [7:0] rd [0:7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_counts();
    cnt_rx = 0; cnt_txr = 0; cnt_unr = 0; cnt_fd = 0;
    for (int i = 0; i < 8; i++) rd[i] = 8'hXX;
  endtask

  // Mode-0 master, half period 8 system clocks; the final falling sck edge
  // and the cs_n release happen together.
  task automatic spi_xfer(input int nbits);
    cs_n = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      mosi = mo[k/8][7 - (k % 8)];
      wait_clks(8);
      sck = 1'b1;
      rd[k/8][7 - (k % 8)] = miso;
      wait_clks(8);
      sck = 1'b0;
      if (k == nbits - 1) cs_n = 1'b1;
    end
    wait_clks(20);
  endtask

  // Compare/monitor process: received bytes against the expected queue,
  // reset values while rst_n is low, event counts, and the tx byte source.
  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clock);
      #1;
      if (!rst_n) begin
        chk("rst_ctrl", {miso, miso_oe, rx_valid, tx_ready, underrun, busy, frame_done, bit_cnt}, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_byte_cnt", byte_cnt, 0);
      end
      if (rx_valid) begin
        cnt_rx++;
        if (exp_rx.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_unexpected: got rx_valid with %0h expected none at %0t", rx_data, $time);
        end else begin
          chk("rx_data", rx_data, exp_rx.pop_front());
        end
      end
      if (tx_ready)   cnt_txr++;
      if (underrun)   cnt_unr++;
      if (frame_done) cnt_fd++;
      if (tx_ready && tx_q.size() != 0) void'(tx_q.pop_front());
      tx_valid = (tx_q.size() != 0);
      tx_data  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    end
  end

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    clear_counts();
    wait_clks(4);
    chk("reset_miso_oe", miso_oe, 0);
    rst_n = 1'b1;
    wait_clks(10);

    // single byte: tx 3C, master writes A5
    clear_counts();
    tx_q.push_back(8'h3C);
    exp_rx.push_back(8'hA5);
    mo[0] = 8'hA5;
    wait_clks(2);
    spi_xfer(8);
    chk("single_miso_byte", rd[0], 8'h3C);
    chk("single_rx_data", rx_data, 8'hA5);
    chk("single_rx_cnt", cnt_rx, 1);
    chk("single_byte_cnt", byte_cnt, 1);
    chk("single_tx_ready", cnt_txr, 1);
    chk("single_frame_done", cnt_fd, 1);
    chk("single_busy_after", busy, 0);

    // burst: 00..04 written, 10..14 supplied
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      mo[i] = 8'(i);
      exp_rx.push_back(8'(i));
      tx_q.push_back(8'(8'h10 + i));
    end
    wait_clks(2);
    spi_xfer(40);
    for (int i = 0; i < 5; i++) chk($sformatf("burst_miso_%0d", i), rd[i], 8'(8'h10 + i));
    chk("burst_rx_cnt", cnt_rx, 5);
    chk("burst_byte_cnt", byte_cnt, 5);
    chk("burst_tx_ready", cnt_txr, 5);
    chk("burst_underrun", cnt_unr, 0);

    // underrun: nothing supplied for a 2-byte read
    clear_counts();
    mo[0] = 8'hAA; mo[1] = 8'h55;
    exp_rx.push_back(8'hAA);
    exp_rx.push_back(8'h55);
    spi_xfer(16);
    chk("unr_miso_0", rd[0], 8'h00);
    chk("unr_miso_1", rd[1], 8'h00);
    chk("unr_underrun", cnt_unr, 2);
    chk("unr_tx_ready", cnt_txr, 0);
    chk("unr_rx_cnt", cnt_rx, 2);

    // abort after 3 bits of FF, then a full frame of 5A
    clear_counts();
    mo[0] = 8'hFF;
    spi_xfer(3);
    chk("abort_rx_cnt", cnt_rx, 0);
    chk("abort_bit_cnt", bit_cnt, 0);
    chk("abort_byte_cnt", byte_cnt, 0);
    chk("abort_frame_done", cnt_fd, 1);
    clear_counts();
    mo[0] = 8'h5A;
    exp_rx.push_back(8'h5A);
    spi_xfer(8);
    chk("post_abort_rx_data", rx_data, 8'h5A);
    chk("post_abort_rx_cnt", cnt_rx, 1);

    // reset held for 3 clocks after 4 bits while sck keeps running
    clear_counts();
    mo[0] = 8'h0F;
    fork
      spi_xfer(8);
      begin
        wait_clks(74);
        rst_n = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
      end
    join
    chk("rstmid_rx_cnt", cnt_rx, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_bit_cnt", bit_cnt, 0);
    chk("rstmid_byte_cnt", byte_cnt, 0);
    chk("rstmid_frame_done", cnt_fd, 0);
    chk("rstmid_rx_data", rx_data, 0);

    clear_counts();
    mo[0] = 8'hC3;
    exp_rx.push_back(8'hC3);
    tx_q.push_back(8'h77);
    wait_clks(2);
    spi_xfer(8);
    chk("post_rst_rx_data", rx_data, 8'hC3);
    chk("post_rst_rx_cnt", cnt_rx, 1);
    chk("post_rst_miso", rd[0], 8'h77);

    chk("exp_rx_drained", exp_rx.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
